// File: rtl/note_player_ctrl_if.sv
// rtl/note_player_ctrl_if.sv - command, ROM, sine_reader and codec signals of note_player_ctrl
//
// Ports (slave = controller view):
//   in  play_enable, load_new_note, note_in, duration_in, beat   command/beat source
//   in  generate_next_sample                                     codec sample request
//   out freq_addr / in freq_step_in                              frequency ROM (1-cycle read)
//   out step_size, reader_clear, reader_gen_next                 to sine_reader
//   in  reader_sample                                            from sine_reader (2-cycle latency)
//   out sample_out, new_sample_ready                             to codec
//   out done_with_note, busy                                     status to sequencer
interface note_player_ctrl_if #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6,
  parameter int STEP_W = 20,
  parameter int SAMP_W = 16
) ();
  logic              play_enable;
  logic              load_new_note;
  logic [NOTE_W-1:0] note_in;
  logic [DUR_W-1:0]  duration_in;
  logic              beat;
  logic              generate_next_sample;
  logic [NOTE_W-1:0] freq_addr;
  logic [STEP_W-1:0] freq_step_in;
  logic [STEP_W-1:0] step_size;
  logic              reader_clear;
  logic              reader_gen_next;
  logic [SAMP_W-1:0] reader_sample;
  logic [SAMP_W-1:0] sample_out;
  logic              new_sample_ready;
  logic              done_with_note;
  logic              busy;

  modport master (
    output play_enable, load_new_note, note_in, duration_in, beat,
           generate_next_sample, freq_step_in, reader_sample,
    input  freq_addr, step_size, reader_clear, reader_gen_next,
           sample_out, new_sample_ready, done_with_note, busy
  );

  modport slave (
    input  play_enable, load_new_note, note_in, duration_in, beat,
           generate_next_sample, freq_step_in, reader_sample,
    output freq_addr, step_size, reader_clear, reader_gen_next,
           sample_out, new_sample_ready, done_with_note, busy
  );
endinterface

// File: rtl/note_player_ctrl.sv
// rtl/note_player_ctrl.sv - single-voice note sequencing controller
//
// Ports:
//   clk    in  system clock
//   reset  in  synchronous active-high reset
//   bus    note_player_ctrl_if.slave: command (note/duration/beat/play_enable),
//          frequency ROM lookup, sine_reader control and sample return,
//          codec sample request/response, done_with_note and busy status
module note_player_ctrl #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6,
  parameter int STEP_W = 20,
  parameter int SAMP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  note_player_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOOKUP1 = 2'd1;
  localparam logic [1:0] S_LOOKUP2 = 2'd2;
  localparam logic [1:0] S_PLAY    = 2'd3;

  logic [1:0]        state;
  logic [NOTE_W-1:0] note_q;
  logic [DUR_W-1:0]  dur_q;
  logic [DUR_W-1:0]  remaining;
  logic [STEP_W-1:0] step_q;
  logic [SAMP_W-1:0] sample_q;
  logic              done_q;
  logic              ready_q;
  // Request tracking: bit 0 = one cycle after the request, bit 1 = two cycles
  // after; ready_q is the third stage.
  logic [1:0]        req_v;
  logic [1:0]        req_m;

  logic fwd;
  logic accept_load;
  logic beat_en;
  logic expire;

  // Requests reach sine_reader only while a real note is audibly playing;
  // otherwise the phase is held and a zero sample is returned.
  assign fwd         = (state == S_PLAY) && bus.play_enable && (note_q != '0);
  assign accept_load = bus.load_new_note && ((state == S_IDLE) || (state == S_PLAY));
  // A load in PLAY wins over a same-cycle beat, so it suppresses the beat.
  assign beat_en     = (state == S_PLAY) && !bus.load_new_note && bus.beat && bus.play_enable;
  assign expire      = beat_en && (remaining == DUR_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      note_q    <= '0;
      dur_q     <= '0;
      remaining <= '0;
      step_q    <= '0;
      sample_q  <= '0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
      req_v     <= '0;
      req_m     <= '0;
    end else begin
      if (accept_load) begin
        note_q <= bus.note_in;
        dur_q  <= bus.duration_in;
      end

      case (state)
        S_IDLE: begin
          if (bus.load_new_note) state <= S_LOOKUP1;
        end
        S_LOOKUP1: begin
          state <= S_LOOKUP2;
        end
        S_LOOKUP2: begin
          step_q    <= bus.freq_step_in;
          remaining <= dur_q;
          state     <= (dur_q == '0) ? S_IDLE : S_PLAY;
        end
        default: begin
          if (bus.load_new_note) begin
            state <= S_LOOKUP1;
          end else if (beat_en) begin
            // remaining is at least 1 in PLAY, so this cannot wrap.
            remaining <= remaining - DUR_W'(1);
            if (expire) state <= S_IDLE;
          end
        end
      endcase

      done_q <= expire || ((state == S_LOOKUP2) && (dur_q == '0));

      req_v   <= {req_v[0], bus.generate_next_sample};
      req_m   <= {req_m[0], !fwd};
      ready_q <= req_v[1];
      if (req_v[1]) sample_q <= req_m[1] ? '0 : bus.reader_sample;
    end
  end

  assign bus.freq_addr        = note_q;
  assign bus.step_size        = step_q;
  assign bus.reader_clear     = (state == S_LOOKUP1) || (state == S_LOOKUP2);
  assign bus.reader_gen_next  = bus.generate_next_sample && fwd;
  assign bus.sample_out       = sample_q;
  assign bus.new_sample_ready = ready_q;
  assign bus.done_with_note   = done_q;
  assign bus.busy             = (state != S_IDLE);

endmodule

// File: tb/tb_note_player_ctrl.sv
// tb/tb_note_player_ctrl.sv - directed self-checking bench for note_player_ctrl
module tb_note_player_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  note_player_ctrl_if bus ();
  note_player_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  int vectors = 0;
  int fails   = 0;
  int n_ready = 0;

  logic [15:0] sb[$];
  logic [15:0] next_val = 16'h0;
  logic [15:0] mon_exp;

  // Frequency ROM model: registered read, data valid one cycle after address.
  function automatic logic [19:0] rom(input logic [5:0] n);
    return (n == 6'd5) ? 20'h00A3C : {8'h00, n, 6'h2A};
  endfunction

  always @(posedge clk) bus.freq_step_in <= rom(bus.freq_addr);

  // sine_reader model: a gen_next in cycle t returns next_val (as seen at t) in t+2.
  logic [1:0]  gpipe = 2'b00;
  logic [15:0] v1 = 16'h0;
  logic [15:0] v2 = 16'h0;
  always @(posedge clk) begin
    gpipe <= {gpipe[0], bus.reader_gen_next};
    v1    <= next_val;
    v2    <= v1;
  end
  assign bus.reader_sample = gpipe[1] ? v2 : 16'hBEEF;

  // Scoreboard consumer: every ready strobe must match the oldest pending request.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.new_sample_ready === 1'b1) begin
      n_ready++;
      vectors++;
      assert (sb.size() > 0) else begin
        fails++;
        $error("FAIL sb_underflow observed=ready_strobe expected=no_pending_request");
      end
      if (sb.size() > 0) begin
        mon_exp = sb.pop_front();
        vectors++;
        assert (bus.sample_out === mon_exp) else begin
          fails++;
          $error("FAIL sample_out observed=%h expected=%h", bus.sample_out, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_step"},   32'(bus.step_size), 32'h0);
    chk({tag, "_sample"}, 32'(bus.sample_out), 32'h0);
    chk({tag, "_ready"},  32'(bus.new_sample_ready), 32'h0);
    chk({tag, "_done"},   32'(bus.done_with_note), 32'h0);
    chk({tag, "_clear"},  32'(bus.reader_clear), 32'h0);
    chk({tag, "_gen"},    32'(bus.reader_gen_next), 32'h0);
    chk({tag, "_busy"},   32'(bus.busy), 32'h0);
    chk({tag, "_faddr"},  32'(bus.freq_addr), 32'h0);
  endtask

  task automatic load(input logic [5:0] n, input logic [5:0] d);
    bus.load_new_note = 1'b1;
    bus.note_in       = n;
    bus.duration_in   = d;
    tick();
    bus.load_new_note = 1'b0;
  endtask

  task automatic do_beat();
    bus.beat = 1'b1;
    tick();
    bus.beat = 1'b0;
  endtask

  task automatic request(input logic fwd);
    bus.generate_next_sample = 1'b1;
    #1;
    chk("gen_next", 32'(bus.reader_gen_next), 32'(fwd));
    sb.push_back(fwd ? next_val : 16'h0);
    tick();
    bus.generate_next_sample = 1'b0;
  endtask

  initial begin
    // Reset with every input active.
    reset = 1'b1;
    bus.play_enable = 1'b1;
    bus.load_new_note = 1'b1;
    bus.note_in = 6'd5;
    bus.duration_in = 6'd3;
    bus.beat = 1'b1;
    bus.generate_next_sample = 1'b1;
    tick();
    tick();
    chk_all_zero("in_reset");
    reset = 1'b0;
    bus.load_new_note = 1'b0;
    bus.beat = 1'b0;
    bus.generate_next_sample = 1'b0;
    tick();
    chk_all_zero("after_reset");

    // Note 5, 3 beats: lookup timing and step capture.
    load(6'd5, 6'd3);
    chk("c1_clear", 32'(bus.reader_clear), 32'h1);
    chk("c1_busy",  32'(bus.busy), 32'h1);
    chk("c1_faddr", 32'(bus.freq_addr), 32'd5);
    chk("c1_step",  32'(bus.step_size), 32'h0);
    tick();
    chk("c2_clear", 32'(bus.reader_clear), 32'h1);
    chk("c2_step",  32'(bus.step_size), 32'h0);
    tick();
    chk("c3_step",  32'(bus.step_size), 32'h00A3C);
    chk("c3_clear", 32'(bus.reader_clear), 32'h0);
    chk("c3_busy",  32'(bus.busy), 32'h1);

    // Forwarded sample, ready exactly at t+3.
    next_val = 16'h1234;
    request(1'b1);
    tick();
    chk("t2_ready", 32'(bus.new_sample_ready), 32'h0);
    tick();
    chk("t3_ready",  32'(bus.new_sample_ready), 32'h1);
    chk("t3_sample", 32'(bus.sample_out), 32'h1234);
    tick();
    chk("t4_ready", 32'(bus.new_sample_ready), 32'h0);

    do_beat();
    do_beat();
    chk("b2_done", 32'(bus.done_with_note), 32'h0);
    chk("b2_busy", 32'(bus.busy), 32'h1);
    do_beat();
    chk("b3_done", 32'(bus.done_with_note), 32'h1);
    chk("b3_busy", 32'(bus.busy), 32'h0);
    tick();
    chk("b3_done_once", 32'(bus.done_with_note), 32'h0);
    chk("step_kept",    32'(bus.step_size), 32'h00A3C);

    // Request while idle is muted but still answered.
    next_val = 16'h5A5A;
    request(1'b0);
    tick(); tick(); tick();

    // Rest note: muted while playing.
    load(6'd0, 6'd1);
    tick(); tick();
    chk("rest_step", 32'(bus.step_size), 32'(rom(6'd0)));
    request(1'b0);
    tick(); tick(); tick();
    do_beat();
    chk("rest_done", 32'(bus.done_with_note), 32'h1);

    // Pause: beats ignored, requests muted.
    load(6'd7, 6'd3);
    tick(); tick();
    bus.play_enable = 1'b0;
    do_beat();
    request(1'b0);
    do_beat();
    do_beat();
    request(1'b0);
    do_beat();
    tick(); tick(); tick();
    chk("pause_done", 32'(bus.done_with_note), 32'h0);
    chk("pause_busy", 32'(bus.busy), 32'h1);
    chk("ready_count", 32'(n_ready), 32'd5);
    bus.play_enable = 1'b1;
    do_beat();
    do_beat();
    chk("resume_b2_done", 32'(bus.done_with_note), 32'h0);
    do_beat();
    chk("resume_done", 32'(bus.done_with_note), 32'h1);
    chk("resume_busy", 32'(bus.busy), 32'h0);

    // Load on the final beat aborts silently; duration 0 finishes in cycle 3.
    load(6'd9, 6'd1);
    tick(); tick();
    bus.beat = 1'b1;
    load(6'd10, 6'd0);
    bus.beat = 1'b0;
    chk("abort_done",  32'(bus.done_with_note), 32'h0);
    chk("abort_clear", 32'(bus.reader_clear), 32'h1);
    chk("abort_faddr", 32'(bus.freq_addr), 32'd10);
    tick();
    chk("d0_c2_done", 32'(bus.done_with_note), 32'h0);
    tick();
    chk("d0_done", 32'(bus.done_with_note), 32'h1);
    chk("d0_busy", 32'(bus.busy), 32'h0);
    chk("d0_step", 32'(bus.step_size), 32'(rom(6'd10)));
    tick();
    chk("d0_done_once", 32'(bus.done_with_note), 32'h0);

    // Back-to-back requests, all delivered in order.
    load(6'd3, 6'd5);
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      next_val = 16'hA000 + 16'(i);
      request(1'b1);
    end
    tick(); tick(); tick(); tick();
    chk("b2b_count", 32'(n_ready), 32'd8);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Back-to-back requests cut off by reset.
    for (int i = 0; i < 3; i++) begin
      next_val = 16'hB000 + 16'(i);
      request(1'b1);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    for (int i = 0; i < 5; i++) begin
      chk("post_reset_ready", 32'(bus.new_sample_ready), 32'h0);
      tick();
    end
    chk("post_reset_step", 32'(bus.step_size), 32'h0);
    chk("post_reset_busy", 32'(bus.busy), 32'h0);
    chk("post_reset_count", 32'(n_ready), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/note_player_ctrl.md
# note_player_ctrl

Sequencing controller for a single sine-wave voice. It accepts a (note, duration) command and looks up the note's phase step in the external frequency ROM. It then drives step_size, phase clear and per-sample generate pulses into `sine_reader`, counts beats until the note expires and pulses `done_with_note`. It sits between the song/music sequencer (command + beat source) and the codec sample-request path.

## Interface
Parameters:
- NOTE_W, 6, note number width; note 0 is a rest
- DUR_W, 6, duration width in beats
- STEP_W, 20, phase step width (matches `sine_reader` step_size)
- SAMP_W, 16, sample width

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- play_enable  in  1  1 = play; 0 = pause (beats ignored, samples muted, phase held)
- load_new_note  in  1  one-cycle command strobe
- note_in  in  NOTE_W  note number, sampled with load_new_note
- duration_in  in  DUR_W  length in beats, sampled with load_new_note
- beat  in  1  one-cycle beat tick
- generate_next_sample  in  1  one-cycle codec sample request
- freq_addr  out  NOTE_W  frequency ROM address; combinational from the latched note
- freq_step_in  in  STEP_W  frequency ROM data; valid one cycle after freq_addr
- step_size  out  STEP_W  registered step to `sine_reader`
- reader_clear  out  1  phase clear to `sine_reader` reset
- reader_gen_next  out  1  generate_next to `sine_reader`
- reader_sample  in  SAMP_W  sample from `sine_reader`; valid 2 cycles after reader_gen_next
- sample_out  out  SAMP_W  registered output sample
- new_sample_ready  out  1  one-cycle strobe; sample_out is valid
- done_with_note  out  1  one-cycle strobe when a note expires
- busy  out  1  state != IDLE

## Operation
- State machine: IDLE, LOOKUP1, LOOKUP2, PLAY.
- IDLE:
  - load_new_note latches note and duration, then goes to LOOKUP1.
  - Other inputs are ignored except sample requests.
- LOOKUP1:
  - freq_addr = latched note; reader_clear = 1.
  - Goes to LOOKUP2 unconditionally.
- LOOKUP2:
  - reader_clear = 1; step_size <= freq_step_in at the end of the cycle.
  - Remaining-beat counter <= duration.
  - If duration == 0: go to IDLE and pulse done_with_note in the next cycle. Otherwise go to PLAY.
- PLAY:
  - load_new_note: latch the new command and go to LOOKUP1. The old note is aborted with no done pulse. Load has priority over a same-cycle beat.
  - beat && play_enable && remaining == 1: done_with_note = 1 in the next cycle; go to IDLE.
  - beat && play_enable && remaining > 1: remaining - 1.
  - beat with play_enable = 0: no effect.
- load_new_note in LOOKUP1/LOOKUP2 is ignored.
- Sample path: every generate_next_sample pulse, in any state, yields exactly one new_sample_ready.
  - Forward condition: state == PLAY && play_enable && note != 0. When true, reader_gen_next = 1 combinationally in the same cycle.
  - When the forward condition is false, the request is muted: reader_gen_next = 0, phase is not advanced, and the returned sample is 0.
  - A 3-stage valid/mute shift register tracks outstanding requests. Back-to-back requests every cycle are supported.
- step_size holds its value outside LOOKUP2. It is 0 after reset and is not cleared on done.

## Timing
- Reset values: step_size 0, sample_out 0, all strobes 0, reader_clear 0, busy 0, freq_addr 0, state IDLE, remaining 0.
- The sample shift register is cleared on reset. Requests outstanding at reset never produce new_sample_ready.
- Command latency, with load sampled in cycle 0:
  - LOOKUP1 in cycle 1, LOOKUP2 in cycle 2.
  - step_size updates and PLAY starts in cycle 3.
  - busy = 1 in cycles 1..3+.
- Sample latency, with a request in cycle t:
  - reader_gen_next in cycle t.
  - sample_out is registered at the end of cycle t+2 from reader_sample (or 0 if muted).
  - new_sample_ready = 1 in cycle t+3 only.
- Done latency: the expiring beat in cycle t gives done_with_note in cycle t+1, when state is already IDLE. A load in cycle t+1 is accepted.
- Mid-note reset: all state is discarded within one cycle, with no done pulse.
- Counter arithmetic is DUR_W bits unsigned and never underflows (the 0 case exits in LOOKUP2).

## Test plan
- Reset with all inputs active -> all outputs 0 during reset and in the first cycle after; busy 0.
- Load note 5, duration 3, with freq_step_in = 20'h00A3C in cycle 2 -> reader_clear high in cycles 1-2; step_size = 20'h00A3C from cycle 3. Three beats with play_enable = 1 -> done_with_note for one cycle after the third beat; busy drops with it.
- In PLAY (note 5), request in cycle t with reader_sample = 16'h1234 at t+2 -> reader_gen_next at t; new_sample_ready at t+3 with sample_out = 16'h1234. Repeat with note 0 -> no reader_gen_next; sample_out = 0.
- play_enable = 0 during PLAY, with 4 beats and 2 requests -> counter unchanged; 2 ready strobes with sample 0; no reader_gen_next. Re-enable and give 3 beats -> done as normal.
- Load during PLAY on the same cycle as the final beat -> no done pulse; LOOKUP restarts. Load with duration 0 -> done_with_note in cycle 3; state IDLE.
- Requests in three consecutive cycles, then reset in the next cycle -> no new_sample_ready after reset; step_size = 0.
